conv1d_mac_sequencer: RTL and testbench

//  Sequences the 5-tap MAC datapath (ALU) for one 1-D conv layer of the ECG classifier. Streams

---
 rtl/conv1d_mac_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_conv1d_mac_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_mac_sequencer.sv
// Address and control sequencer for one 1-D convolution layer (5-tap MAC).
// Streams activation/weight read addresses to external synchronous-read
// buffers, drives the ALU tap counter in step with the returning data, and
// writes each finished dot product (optionally ReLU-clipped) to the output
// feature-map buffer. Valid convolution only: stride 1, no padding.
module conv1d_mac_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [ADDR_WIDTH-1:0] cfg_len_in,
    input  logic [ADDR_WIDTH-1:0] cfg_ch_in,
    output logic                  rd_en_out,
    output logic [ADDR_WIDTH-1:0] ia_addr_out,
    output logic [ADDR_WIDTH-1:0] w_addr_out,
    output logic [2:0]            ctrl_counter_out,
    input  logic                  alu_valid_in,
    input  logic [DATA_WIDTH-1:0] alu_data_in,
    output logic                  ofm_we_out,
    output logic [ADDR_WIDTH-1:0] ofm_addr_out,
    output logic [DATA_WIDTH-1:0] ofm_data_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  err_out
);

    localparam logic [2:0] LAST_TAP = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_FLUSH
    } state_t;

    state_t r_state, w_stateNxt;

    // Job configuration latched on an accepted start (stored as "last index")
    logic [ADDR_WIDTH-1:0] r_posLast, w_posLastNxt;
    logic [ADDR_WIDTH-1:0] r_chLast,  w_chLastNxt;
    logic [ADDR_WIDTH-1:0] r_winLast, w_winLastNxt;

    // Read-side counters describing the tap currently presented to the buffers
    logic [2:0]            r_k,     w_kNxt;
    logic [ADDR_WIDTH-1:0] r_pos,   w_posNxt;
    logic [ADDR_WIDTH-1:0] r_ch,    w_chNxt;
    logic [ADDR_WIDTH-1:0] r_wBase, w_wBaseNxt;
    logic                  r_flushCnt, w_flushNxt;

    // Write-side counter, advanced only by returning ALU results
    logic [ADDR_WIDTH-1:0] r_wrAddr, w_wrAddrNxt;
    logic                  r_wrDone, w_wrDoneNxt;

    // Registered outputs
    logic                  r_rdEn,   w_rdEnNxt;
    logic [ADDR_WIDTH-1:0] r_iaAddr, w_iaAddrNxt;
    logic [ADDR_WIDTH-1:0] r_wAddr,  w_wAddrNxt;
    logic [2:0]            r_ctrl,   w_ctrlNxt;
    logic                  r_ofmWe,   w_ofmWeNxt;
    logic [ADDR_WIDTH-1:0] r_ofmAddr, w_ofmAddrNxt;
    logic [DATA_WIDTH-1:0] r_ofmData, w_ofmDataNxt;
    logic                  r_busy, w_busyNxt;
    logic                  r_done, w_doneNxt;
    logic                  r_err,  w_errNxt;

    logic                  w_startJob;
    logic                  w_cfgOk;
    logic [ADDR_WIDTH-1:0] w_posCountCfg;
    logic [ADDR_WIDTH-1:0] w_winCountCfg;
    logic                  w_lastTap;
    logic [ADDR_WIDTH-1:0] w_kExt;
    logic                  w_wrAccept;
    logic [DATA_WIDTH-1:0] w_reluData;

    // Configuration checks and derived sizes (P = L-4 positions, W = C*P windows)
    assign w_cfgOk       = (cfg_len_in >= ADDR_WIDTH'(5)) && (cfg_ch_in != '0);
    assign w_posCountCfg = cfg_len_in - ADDR_WIDTH'(4);
    assign w_winCountCfg = cfg_ch_in * w_posCountCfg;
    assign w_lastTap     = (r_k == LAST_TAP) && (r_pos == r_posLast) && (r_ch == r_chLast);

    // Main FSM: next state, read-address stream and status outputs
    always_comb begin
        w_stateNxt   = r_state;
        w_posLastNxt = r_posLast;
        w_chLastNxt  = r_chLast;
        w_winLastNxt = r_winLast;
        w_kNxt       = r_k;
        w_posNxt     = r_pos;
        w_chNxt      = r_ch;
        w_wBaseNxt   = r_wBase;
        w_flushNxt   = r_flushCnt;
        w_rdEnNxt    = 1'b0;
        w_iaAddrNxt  = '0;
        w_wAddrNxt   = '0;
        w_busyNxt    = r_busy;
        w_doneNxt    = 1'b0;
        w_errNxt     = 1'b0;
        w_startJob   = 1'b0;
        w_kExt       = '0;

        case (r_state)
            S_IDLE: begin
                w_busyNxt = 1'b0;
                if (start_in) begin
                    if (w_cfgOk) begin
                        w_startJob   = 1'b1;
                        w_stateNxt   = S_RUN;
                        w_posLastNxt = cfg_len_in - ADDR_WIDTH'(5);
                        w_chLastNxt  = cfg_ch_in - ADDR_WIDTH'(1);
                        w_winLastNxt = w_winCountCfg - ADDR_WIDTH'(1);
                        w_kNxt       = '0;
                        w_posNxt     = '0;
                        w_chNxt      = '0;
                        w_wBaseNxt   = '0;
                        w_rdEnNxt    = 1'b1;
                        w_busyNxt    = 1'b1;
                    end else begin
                        w_errNxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort_in) begin
                    w_stateNxt = S_FLUSH;
                    w_flushNxt = 1'b0;
                end else if (w_lastTap) begin
                    w_stateNxt = S_DRAIN;
                end else begin
                    w_rdEnNxt = 1'b1;
                    if (r_k == LAST_TAP) begin
                        w_kNxt = '0;
                        if (r_pos == r_posLast) begin
                            w_posNxt   = '0;
                            w_chNxt    = r_ch + ADDR_WIDTH'(1);
                            w_wBaseNxt = r_wBase + ADDR_WIDTH'(5);
                        end else begin
                            w_posNxt = r_pos + ADDR_WIDTH'(1);
                        end
                    end else begin
                        w_kNxt = r_k + 3'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (abort_in) begin
                    w_stateNxt = S_FLUSH;
                    w_flushNxt = 1'b0;
                end else if (r_wrDone) begin
                    w_stateNxt = S_DONE;
                    w_doneNxt  = 1'b1;
                    w_busyNxt  = 1'b0;
                end
            end
            S_DONE: begin
                w_stateNxt = S_IDLE;
                w_busyNxt  = 1'b0;
            end
            S_FLUSH: begin
                if (r_flushCnt) begin
                    w_stateNxt = S_IDLE;
                    w_busyNxt  = 1'b0;
                end else begin
                    w_flushNxt = 1'b1;
                end
            end
            default: begin
                w_stateNxt = S_IDLE;
                w_busyNxt  = 1'b0;
            end
        endcase

        if (w_rdEnNxt) begin
            w_kExt      = {{(ADDR_WIDTH-3){1'b0}}, w_kNxt};
            w_iaAddrNxt = w_posNxt + w_kExt;
            w_wAddrNxt  = w_wBaseNxt + w_kExt;
        end

        // The tap index trails the address by one cycle, matching buffer read latency
        w_ctrlNxt = r_rdEn ? r_k : 3'd0;
    end

    // Write path: capture ALU results while a job is active and not yet complete
    always_comb begin
        w_wrAddrNxt  = r_wrAddr;
        w_wrDoneNxt  = r_wrDone;
        w_ofmWeNxt   = 1'b0;
        w_ofmAddrNxt = '0;
        w_ofmDataNxt = '0;
        w_reluData   = (RELU_EN && alu_data_in[DATA_WIDTH-1]) ? '0 : alu_data_in;
        w_wrAccept   = alu_valid_in && !r_wrDone && !abort_in &&
                       ((r_state == S_RUN) || (r_state == S_DRAIN));

        if (w_startJob) begin
            w_wrAddrNxt = '0;
            w_wrDoneNxt = 1'b0;
        end else if (w_wrAccept) begin
            w_ofmWeNxt   = 1'b1;
            w_ofmAddrNxt = r_wrAddr;
            w_ofmDataNxt = w_reluData;
            if (r_wrAddr == r_winLast) begin
                w_wrDoneNxt = 1'b1;
            end else begin
                w_wrAddrNxt = r_wrAddr + ADDR_WIDTH'(1);
            end
        end
    end

    // State, read counters and read-side/status output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_posLast  <= '0;
            r_chLast   <= '0;
            r_winLast  <= '0;
            r_k        <= '0;
            r_pos      <= '0;
            r_ch       <= '0;
            r_wBase    <= '0;
            r_flushCnt <= 1'b0;
            r_rdEn     <= 1'b0;
            r_iaAddr   <= '0;
            r_wAddr    <= '0;
            r_ctrl     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_stateNxt;
            r_posLast  <= w_posLastNxt;
            r_chLast   <= w_chLastNxt;
            r_winLast  <= w_winLastNxt;
            r_k        <= w_kNxt;
            r_pos      <= w_posNxt;
            r_ch       <= w_chNxt;
            r_wBase    <= w_wBaseNxt;
            r_flushCnt <= w_flushNxt;
            r_rdEn     <= w_rdEnNxt;
            r_iaAddr   <= w_iaAddrNxt;
            r_wAddr    <= w_wAddrNxt;
            r_ctrl     <= w_ctrlNxt;
            r_busy     <= w_busyNxt;
            r_done     <= w_doneNxt;
            r_err      <= w_errNxt;
        end
    end

    // Write counter and output-buffer write registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrAddr  <= '0;
            r_wrDone  <= 1'b0;
            r_ofmWe   <= 1'b0;
            r_ofmAddr <= '0;
            r_ofmData <= '0;
        end else begin
            r_wrAddr  <= w_wrAddrNxt;
            r_wrDone  <= w_wrDoneNxt;
            r_ofmWe   <= w_ofmWeNxt;
            r_ofmAddr <= w_ofmAddrNxt;
            r_ofmData <= w_ofmDataNxt;
        end
    end

    assign rd_en_out        = r_rdEn;
    assign ia_addr_out      = r_iaAddr;
    assign w_addr_out       = r_wAddr;
    assign ctrl_counter_out = r_ctrl;
    assign ofm_we_out       = r_ofmWe;
    assign ofm_addr_out     = r_ofmAddr;
    assign ofm_data_out     = r_ofmData;
    assign busy_out         = r_busy;
    assign done_out         = r_done;
    assign err_out          = r_err;

endmodule

// File: tb/tb_conv1d_mac_sequencer.sv
// Testbench for conv1d_mac_sequencer: buffer + MAC responder, scoreboarded
// read stream, tap counter, output writes and status pulses.
module tb_conv1d_mac_sequencer;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_in = 1'b0;
    logic          abort_in = 1'b0;
    logic [AW-1:0] cfg_len_in = '0;
    logic [AW-1:0] cfg_ch_in = '0;
    logic          alu_valid_in;
    logic [DW-1:0] alu_data_in;

    logic          rd_en_out, ofm_we_out, busy_out, done_out, err_out;
    logic [AW-1:0] ia_addr_out, w_addr_out, ofm_addr_out;
    logic [2:0]    ctrl_counter_out;
    logic [DW-1:0] ofm_data_out;

    logic          rd_en0, ofm_we0, busy0, done0, err0;
    logic [AW-1:0] ia_addr0, w_addr0, ofm_addr0;
    logic [2:0]    ctrl0;
    logic [DW-1:0] ofm_data0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int jobE0 = 0;
    int expDoneEdge = -1;
    int expErrEdge = -1;

    typedef struct { int at; logic [AW-1:0] ia; logic [AW-1:0] wa; logic [2:0] k; } rdExp_t;
    typedef struct { int at; logic [AW-1:0] addr; logic [DW-1:0] raw; } wrExp_t;
    rdExp_t rdQ[$];
    wrExp_t wrQ[$];

    logic signed [DW-1:0] iaMem [256];
    logic signed [DW-1:0] wMem  [256];

    logic                 bufValid, mValid, injValid = 1'b0;
    logic signed [DW-1:0] iaQ, wQ;
    logic [DW-1:0]        mData;
    logic signed [31:0]   accum, macSum;

    logic                 mExpRd, mExpWe;
    logic [2:0]           mCtrlExp = 3'd0;
    logic [DW-1:0]        mRelu;

    assign alu_valid_in = mValid | injValid;
    assign alu_data_in  = injValid ? 16'h7777 : mData;

    conv1d_mac_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RELU_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .abort_in(abort_in),
        .cfg_len_in(cfg_len_in), .cfg_ch_in(cfg_ch_in),
        .rd_en_out(rd_en_out), .ia_addr_out(ia_addr_out), .w_addr_out(w_addr_out),
        .ctrl_counter_out(ctrl_counter_out),
        .alu_valid_in(alu_valid_in), .alu_data_in(alu_data_in),
        .ofm_we_out(ofm_we_out), .ofm_addr_out(ofm_addr_out), .ofm_data_out(ofm_data_out),
        .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
    );

    conv1d_mac_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RELU_EN(1'b0)) dutNoRelu (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .abort_in(abort_in),
        .cfg_len_in(cfg_len_in), .cfg_ch_in(cfg_ch_in),
        .rd_en_out(rd_en0), .ia_addr_out(ia_addr0), .w_addr_out(w_addr0),
        .ctrl_counter_out(ctrl0),
        .alu_valid_in(alu_valid_in), .alu_data_in(alu_data_in),
        .ofm_we_out(ofm_we0), .ofm_addr_out(ofm_addr0), .ofm_data_out(ofm_data0),
        .busy_out(busy0), .done_out(done0), .err_out(err0)
    );

    // Free-running clock and edge counter (cyc == n after edge En)
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer + MAC responder: 1-cycle synchronous reads, accumulate on tap counter
    always_comb macSum = ((ctrl_counter_out == 3'd0) ? 32'sd0 : accum) + iaQ * wQ;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bufValid <= 1'b0;
            iaQ      <= '0;
            wQ       <= '0;
            accum    <= '0;
            mValid   <= 1'b0;
            mData    <= '0;
        end else begin
            bufValid <= rd_en_out;
            iaQ      <= iaMem[ia_addr_out];
            wQ       <= wMem[w_addr_out];
            if (bufValid) begin
                accum  <= macSum;
                mValid <= (ctrl_counter_out == 3'd4);
                mData  <= macSum[DW-1:0];
            end else begin
                mValid <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, observed, expected);
        end
    endtask

    // Per-cycle scoreboard of the read stream, tap counter, writes and pulses
    always @(negedge clk) begin
        mExpRd = (rdQ.size() > 0) && (rdQ[0].at == cyc);
        checkOutput("rd_en", rd_en_out, mExpRd);
        if (mExpRd) begin
            checkOutput("ia_addr", ia_addr_out, rdQ[0].ia);
            checkOutput("w_addr", w_addr_out, rdQ[0].wa);
        end
        checkOutput("ctrl_counter", ctrl_counter_out, rst_n ? mCtrlExp : 3'd0);
        mCtrlExp = (mExpRd && rst_n) ? rdQ[0].k : 3'd0;
        if (mExpRd) void'(rdQ.pop_front());

        mExpWe = (wrQ.size() > 0) && (wrQ[0].at == cyc);
        checkOutput("ofm_we", ofm_we_out, mExpWe);
        checkOutput("ofm_we_norelu", ofm_we0, mExpWe);
        if (mExpWe) begin
            mRelu = wrQ[0].raw[DW-1] ? '0 : wrQ[0].raw;
            checkOutput("ofm_addr", ofm_addr_out, wrQ[0].addr);
            checkOutput("ofm_data_relu", ofm_data_out, mRelu);
            checkOutput("ofm_addr_norelu", ofm_addr0, wrQ[0].addr);
            checkOutput("ofm_data_norelu", ofm_data0, wrQ[0].raw);
            void'(wrQ.pop_front());
        end

        checkOutput("done", done_out, cyc == expDoneEdge);
        checkOutput("err", err_out, cyc == expErrEdge);
    end

    task automatic waitCycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic loadData(input int mode);
        for (int i = 0; i < 256; i++) begin
            iaMem[i] = (mode == 0) ? DW'(((i * 7) % 11) - 5) : -16'sd1;
            wMem[i]  = (mode == 0) ? DW'(((i * 3) % 7) - 3) : 16'sd1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " rd_en"}, rd_en_out, 0);
        checkOutput({tag, " ia_addr"}, ia_addr_out, 0);
        checkOutput({tag, " w_addr"}, w_addr_out, 0);
        checkOutput({tag, " ctrl"}, ctrl_counter_out, 0);
        checkOutput({tag, " ofm_we"}, ofm_we_out, 0);
        checkOutput({tag, " ofm_addr"}, ofm_addr_out, 0);
        checkOutput({tag, " ofm_data"}, ofm_data_out, 0);
        checkOutput({tag, " busy"}, busy_out, 0);
        checkOutput({tag, " done"}, done_out, 0);
        checkOutput({tag, " err"}, err_out, 0);
    endtask

    // Called at a negedge; drives one start and records what the job must produce
    task automatic applyStimulus(input int len, input int ch);
        int nPos, win, sum;
        start_in   = 1'b1;
        cfg_len_in = AW'(len);
        cfg_ch_in  = AW'(ch);
        jobE0      = cyc + 1;
        if (len >= 5 && ch > 0) begin
            nPos = len - 4;
            for (int c = 0; c < ch; c++) begin
                for (int p = 0; p < nPos; p++) begin
                    win = c * nPos + p;
                    sum = 0;
                    for (int k = 0; k < 5; k++) begin
                        rdQ.push_back('{at: jobE0 + 5 * win + k, ia: AW'(p + k), wa: AW'(5 * c + k), k: 3'(k)});
                        sum += int'(iaMem[p + k]) * int'(wMem[5 * c + k]);
                    end
                    wrQ.push_back('{at: jobE0 + 5 * win + 7, addr: AW'(win), raw: sum[DW-1:0]});
                end
            end
            expDoneEdge = jobE0 + 5 * ch * nPos + 3;
        end else begin
            expErrEdge = jobE0;
        end
        @(negedge clk);
        start_in   = 1'b0;
        cfg_len_in = 8'hFF;
        cfg_ch_in  = 8'h7F;
    endtask

    // Runs to the end of the current job; a stray valid after the last write must be ignored
    task automatic finishJob();
        waitCycle(expDoneEdge - 1);
        checkOutput("busy before done", busy_out, 1);
        injValid = 1'b1;
        @(negedge clk);
        injValid = 1'b0;
        checkOutput("busy at done", busy_out, 0);
        @(negedge clk);
        checkOutput("busy after done", busy_out, 0);
    endtask

    task automatic purgeFrom(input int lim);
        while (rdQ.size() > 0 && rdQ[$].at >= lim) void'(rdQ.pop_back());
        while (wrQ.size() > 0 && wrQ[$].at >= lim) void'(wrQ.pop_back());
    endtask

    initial begin
        #50000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] job L=9 C=1 with ignored start while busy");
        loadData(0);
        applyStimulus(9, 1);
        checkOutput("busy after start", busy_out, 1);
        waitCycle(jobE0 + 3);
        start_in = 1'b1;
        cfg_len_in = 8'd20;
        cfg_ch_in = 8'd3;
        @(negedge clk);
        start_in = 1'b0;
        finishJob();

        $display("[TB] job L=6 C=2");
        applyStimulus(6, 2);
        finishJob();

        $display("[TB] job L=9 C=1, activations -1, weights +1");
        loadData(1);
        applyStimulus(9, 1);
        finishJob();

        $display("[TB] rejected configurations");
        applyStimulus(4, 1);
        checkOutput("busy after bad L", busy_out, 0);
        injValid = 1'b1;
        @(negedge clk);
        injValid = 1'b0;
        applyStimulus(9, 0);
        checkOutput("busy after bad C", busy_out, 0);
        @(negedge clk);

        $display("[TB] abort at E10 then restart");
        loadData(0);
        applyStimulus(9, 1);
        waitCycle(jobE0 + 9);
        abort_in = 1'b1;
        purgeFrom(jobE0 + 10);
        expDoneEdge = -1;
        @(negedge clk);
        abort_in = 1'b0;
        start_in = 1'b1;
        checkOutput("busy flush 1", busy_out, 1);
        @(negedge clk);
        start_in = 1'b0;
        checkOutput("busy flush 2", busy_out, 1);
        @(negedge clk);
        checkOutput("busy after flush", busy_out, 0);
        applyStimulus(9, 1);
        finishJob();

        $display("[TB] reset mid-job then restart");
        applyStimulus(9, 1);
        waitCycle(jobE0 + 14);
        @(posedge clk);
        #2 rst_n = 1'b0;
        rdQ.delete();
        wrQ.delete();
        expDoneEdge = -1;
        #1 checkAllZero("async reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(9, 1);
        finishJob();

        checkOutput("read queue drained", rdQ.size(), 0);
        checkOutput("write queue drained", wrQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
